// File: rtl/kovacs_phase_decoder.sv
// Kovacs phase decoder: classifies a 14-bit indicator level into HIGH/MID/LOW,
// debounces the classification, tracks the legal HIGH->LOW->MID->HIGH sequence
// and measures the length of each phase in clock cycles.
module kovacs_phase_decoder #(
    parameter int CNT_W = 32,
    parameter int ERR_W = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [13:0]      indicator_i,
    input  logic [13:0]      th_hi_i,
    input  logic [13:0]      th_lo_i,
    input  logic [7:0]       deb_i,
    input  logic             clear_i,
    output logic [1:0]       phase_o,
    output logic             locked_o,
    output logic             cycle_start_o,
    output logic [CNT_W-1:0] t_high_o,
    output logic [CNT_W-1:0] t_low_o,
    output logic [CNT_W-1:0] t_mid_o,
    output logic             meas_valid_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [ERR_W-1:0] error_count_o
);

    // Level codes match the phase_o encoding so a locked state maps 1:1 to a level.
    localparam logic [1:0] LVL_HIGH = 2'd0;
    localparam logic [1:0] LVL_MID  = 2'd1;
    localparam logic [1:0] LVL_LOW  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_HIGH     = 2'd0,
        ST_MID      = 2'd1,
        ST_LOW      = 2'd2,
        ST_UNLOCKED = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [13:0]      r_ind_q;
    logic [1:0]       r_acc_lvl;
    logic             r_acc_vld;     // 0 = accepted level NONE
    logic [1:0]       r_cand;
    logic [8:0]       r_deb_cnt;
    logic [CNT_W-1:0] r_ph_cnt;
    logic [CNT_W-1:0] r_t_high;
    logic [CNT_W-1:0] r_t_low;
    logic [CNT_W-1:0] r_t_mid;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_cyc_start;
    logic             r_meas_valid;

    logic [1:0]       w_cls;
    logic [8:0]       w_run;
    logic             w_same;
    logic             w_accept;
    logic             w_trans;
    logic             w_legal;
    logic             w_lock_evt;
    logic             w_cycle_evt;
    logic             w_leave_evt;
    logic             w_err_evt;

    // Classify the registered indicator; HIGH wins if thresholds overlap.
    always_comb begin
        w_cls = LVL_MID;
        if (r_ind_q >= th_hi_i)
            w_cls = LVL_HIGH;
        else if (r_ind_q < th_lo_i)
            w_cls = LVL_LOW;
    end

    // Debounce run length including this cycle; acceptance fires when it exceeds deb_i.
    always_comb begin
        w_run    = ((w_cls == r_cand) && (r_deb_cnt != 9'd0)) ? (r_deb_cnt + 9'd1) : 9'd1;
        w_same   = r_acc_vld && (w_cls == r_acc_lvl);
        w_accept = !w_same && (w_run > {1'b0, deb_i});
        // The first acceptance out of NONE is not a transition.
        w_trans  = w_accept && r_acc_vld && !clear_i;
        w_legal  = ((r_state == ST_HIGH) && (w_cls == LVL_LOW)) ||
                   ((r_state == ST_LOW)  && (w_cls == LVL_MID)) ||
                   ((r_state == ST_MID)  && (w_cls == LVL_HIGH));
    end

    // Input register, debounce counter and accepted level; clear keeps the accepted level.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ind_q   <= '0;
            r_acc_lvl <= LVL_HIGH;
            r_acc_vld <= 1'b0;
            r_cand    <= LVL_HIGH;
            r_deb_cnt <= '0;
        end else begin
            r_ind_q <= indicator_i;
            if (clear_i || w_same) begin
                r_deb_cnt <= '0;
            end else if (w_accept) begin
                r_acc_lvl <= w_cls;
                r_acc_vld <= 1'b1;
                r_deb_cnt <= '0;
            end else begin
                r_cand    <= w_cls;
                r_deb_cnt <= w_run;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_state <= ST_UNLOCKED;
        else
            r_state <= w_state_next;
    end

    // FSM next state: lock on MID->HIGH, follow the legal ring, drop lock on anything else.
    always_comb begin
        w_state_next = r_state;
        w_lock_evt   = 1'b0;
        w_cycle_evt  = 1'b0;
        w_leave_evt  = 1'b0;
        w_err_evt    = 1'b0;
        if (clear_i) begin
            w_state_next = ST_UNLOCKED;
        end else if (w_trans) begin
            if (r_state == ST_UNLOCKED) begin
                if ((r_acc_lvl == LVL_MID) && (w_cls == LVL_HIGH)) begin
                    w_state_next = ST_HIGH;
                    w_lock_evt   = 1'b1;
                end
            end else if (w_legal) begin
                w_state_next = state_t'(w_cls);
                w_leave_evt  = 1'b1;
                w_cycle_evt  = (r_state == ST_MID);
            end else begin
                w_state_next = ST_UNLOCKED;
                w_err_evt    = 1'b1;
            end
        end
    end

    // FSM outputs: phase code is the state code itself.
    always_comb begin
        phase_o  = r_state;
        locked_o = (r_state != ST_UNLOCKED);
    end

    // Phase timer, measurements, counters and one-cycle pulses.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ph_cnt     <= '0;
            r_t_high     <= '0;
            r_t_low      <= '0;
            r_t_mid      <= '0;
            r_cyc_cnt    <= '0;
            r_err_cnt    <= '0;
            r_cyc_start  <= 1'b0;
            r_meas_valid <= 1'b0;
        end else begin
            r_cyc_start  <= w_lock_evt || w_cycle_evt;
            r_meas_valid <= w_cycle_evt;
            if (clear_i) begin
                r_ph_cnt  <= '0;
                r_t_high  <= '0;
                r_t_low   <= '0;
                r_t_mid   <= '0;
                r_cyc_cnt <= '0;
                r_err_cnt <= '0;
            end else begin
                if (w_lock_evt || w_leave_evt)
                    r_ph_cnt <= CNT_ONE;
                else if (w_state_next == ST_UNLOCKED)
                    r_ph_cnt <= '0;
                else if (r_ph_cnt != '1)
                    r_ph_cnt <= r_ph_cnt + CNT_ONE;
                if (w_leave_evt) begin
                    case (r_state)
                        ST_HIGH: r_t_high <= r_ph_cnt;
                        ST_LOW:  r_t_low  <= r_ph_cnt;
                        default: r_t_mid  <= r_ph_cnt;
                    endcase
                end
                if (w_cycle_evt)
                    r_cyc_cnt <= r_cyc_cnt + CNT_ONE;
                if (w_err_evt && (r_err_cnt != '1))
                    r_err_cnt <= r_err_cnt + ERR_ONE;
            end
        end
    end

    assign cycle_start_o = r_cyc_start;
    assign meas_valid_o  = r_meas_valid;
    assign t_high_o      = r_t_high;
    assign t_low_o       = r_t_low;
    assign t_mid_o       = r_t_mid;
    assign cycle_count_o = r_cyc_cnt;
    assign error_count_o = r_err_cnt;

endmodule
